// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract,
// one bit per cycle. MTHI/MTLO write HI/LO directly when the unit is idle.
// Optional feature macro MULDIV_SIGNED_EN: when defined, MULT and DIV use signed
// semantics. Without it they behave as MULTU/DIVU and no sign logic is built.
module muldiv_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   a_q;      // multiplicand or divisor magnitude
    logic [W-1:0]   rem_q;    // product upper half / partial remainder
    logic [W-1:0]   quo_q;    // multiplier bits / dividend bits then quotient
    logic [W-1:0]   hi_q, lo_q;
    logic           isdiv_q;
    logic           done_q;

    logic           accept, step_en, fix_en;
    logic [W-1:0]   mag_x, mag_y;
    logic [W-1:0]   fix_hi, fix_lo;
    logic [W:0]     mul_sum, div_sh, div_sub;
    logic [W-1:0]   rem_nx, quo_nx;

`ifdef MULDIV_SIGNED_EN
    logic           sgn_op, sx, sy;
    logic           neg_q;    // quotient/product must be negated
    logic           negr_q;   // remainder takes the dividend sign
    logic [2*W-1:0] prod;

    assign sgn_op = (op == 3'd0) || (op == 3'd2);
    assign sx     = sgn_op & x[W-1];
    assign sy     = sgn_op & y[W-1];
    assign mag_x  = sx ? -x : x;
    assign mag_y  = sy ? -y : y;

    // Record result signs when an operation is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
        end else if (accept) begin
            neg_q  <= sx ^ sy;
            negr_q <= sx;
        end
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod   = {rem_q, quo_q};
        fix_hi = rem_q;
        fix_lo = quo_q;
        if (isdiv_q) begin
            if (neg_q)  fix_lo = -quo_q;
            if (negr_q) fix_hi = -rem_q;
        end else if (neg_q) begin
            {fix_hi, fix_lo} = -prod;
        end
    end
`else
    assign mag_x  = x;
    assign mag_y  = y;
    assign fix_hi = rem_q;
    assign fix_lo = quo_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: RUN lasts exactly W edges, FIX one edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !op[2]) state_d = RUN;
            RUN:     if (cnt_q == CW'(W - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy spans RUN and FIX, so a start in the done cycle is accepted
    always_comb begin
        busy    = 1'b0;
        accept  = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        case (state_q)
            IDLE: accept = start && !op[2];
            RUN: begin
                busy    = 1'b1;
                step_en = 1'b1;
            end
            FIX: begin
                busy   = 1'b1;
                fix_en = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        div_sh  = {rem_q, quo_q[W-1]};
        div_sub = div_sh - {1'b0, a_q};
        rem_nx  = mul_sum[W:1];
        quo_nx  = {mul_sum[0], quo_q[W-1:1]};
        if (isdiv_q) begin
            if (div_sh >= {1'b0, a_q}) begin
                rem_nx = div_sub[W-1:0];
                quo_nx = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_nx = div_sh[W-1:0];
                quo_nx = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    // Datapath, counter and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            isdiv_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fix_en;
            if (accept) begin
                a_q     <= mag_y;
                quo_q   <= mag_x;
                rem_q   <= '0;
                cnt_q   <= '0;
                isdiv_q <= op[1];
            end else if (step_en) begin
                cnt_q <= cnt_q + 1'b1;
                rem_q <= rem_nx;
                quo_q <= quo_nx;
            end
            if (fix_en) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (state_q == IDLE && start) begin
                if (op == 3'd4) hi_q <= x;
                if (op == 3'd5) lo_q <= x;
            end
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] x, y;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int cyc, busy_bad, hold_bad;
    logic [31:0] h0, l0;
    logic [63:0] r;
    logic [31:0] exp_hi, exp_lo;
    int done_seen;

    always #5 clk = ~clk;

    muldiv_seq #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi,lo} from plain arithmetic on the operation's meaning
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        int ia, ib;
        longint sa, sb, q, rm;
        logic [63:0] res;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = 1'b1;
`endif
        ia = a; ib = b; sa = ia; sb = ib;
        res = '0;
        case (o)
            3'd0, 3'd1: begin
                if (sgn && o == 3'd0) res = sa * sb;
                else                  res = {32'd0, a} * {32'd0, b};
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    if (sgn && o == 3'd2 && a[31]) res = {a, 32'd1};
                    else                           res = {a, 32'hFFFF_FFFF};
                end else if (sgn && o == 3'd2) begin
                    q = sa / sb; rm = sa % sb;
                    res = {rm[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; x = a; y = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_bad = 0; hold_bad = 0;
    endtask

    task automatic tick();
        if (busy !== 1'b1) busy_bad++;
        if (hi !== h0 || lo !== l0) hold_bad++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el);
        while (done !== 1'b1 && cyc < 40) tick();
        chk({tag, ".latency"}, cyc, 33);
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".hi"}, hi, eh);
        chk({tag, ".lo"}, lo, el);
        chk({tag, ".busy_during_run"}, busy_bad, 0);
        chk({tag, ".hilo_hold"}, hold_bad, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'd0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        chk("reset.hi", hi, 0);
        chk("reset.lo", lo, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);

        // First start on the first edge after reset release
        rst_n = 1'b1;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        chk("multu_max.done_pulse", done, 0);

`ifdef MULDIV_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
`else
        exp_hi = 32'h0000_0002; exp_lo = 32'hFFFF_FFFA;
`endif
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done("mult_neg2x3", exp_hi, exp_lo);
        @(negedge clk);

`ifdef MULDIV_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
`else
        exp_hi = 32'h0000_0001; exp_lo = 32'h7FFF_FFFC;
`endif
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg7by2", exp_hi, exp_lo);
        @(negedge clk);

        issue(3'd3, 32'd7, 32'd0);
        wait_done("divu_by0", 32'd7, 32'hFFFF_FFFF);
        @(negedge clk);

`ifdef MULDIV_SIGNED_EN
        exp_hi = 32'h0000_0000; exp_lo = 32'h8000_0000;
`else
        exp_hi = 32'h8000_0000; exp_lo = 32'h0000_0000;
`endif
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_by_m1", exp_hi, exp_lo);
        @(negedge clk);

`ifdef MULDIV_SIGNED_EN
        exp_hi = 32'hFFFF_FFF0; exp_lo = 32'h0000_0001;
`else
        exp_hi = 32'hFFFF_FFF0; exp_lo = 32'hFFFF_FFFF;
`endif
        issue(3'd2, 32'hFFFF_FFF0, 32'd0);
        wait_done("div_neg_by0", exp_hi, exp_lo);
        @(negedge clk);

        // Requests while busy are ignored
        issue(3'd3, 32'd100, 32'd7);
        repeat (4) tick();
        start = 1'b1; op = 3'd5; x = 32'h1234;
        tick();
        op = 3'd1; x = 32'd3; y = 32'd5;
        tick();
        start = 1'b0;
        wait_done("divu_ignore", 32'd2, 32'd14);
        @(negedge clk);
        chk("divu_ignore.done_pulse", done, 0);

        // Moves and no-ops in idle
        start = 1'b1; op = 3'd5; x = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo.lo", lo, 32'h1234);
        chk("mtlo.hi_kept", hi, 32'd2);
        chk("mtlo.busy", busy, 0);
        chk("mtlo.done", done, 0);
        @(negedge clk);
        chk("mtlo.done_after", done, 0);
        start = 1'b1; op = 3'd4; x = 32'hABCD;
        @(negedge clk);
        start = 1'b0;
        chk("mthi.hi", hi, 32'hABCD);
        chk("mthi.lo_kept", lo, 32'h1234);
        chk("mthi.busy", busy, 0);
        start = 1'b1; op = 3'd6; x = 32'h5555; y = 32'h7;
        @(negedge clk);
        chk("op6.busy", busy, 0);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("op67.busy", busy, 0);
        chk("op67.done", done, 0);
        chk("op67.hi", hi, 32'hABCD);
        chk("op67.lo", lo, 32'h1234);

        // Back-to-back: second start in the done cycle
        issue(3'd1, 32'd1000, 32'd1000);
        wait_done("b2b_first", 32'd0, 32'd1000000);
        issue(3'd1, 32'd3, 32'd5);
        wait_done("b2b_second", 32'd0, 32'd15);

        // Randomized operations, each issued in the previous done cycle
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            if (i % 4 == 1) ra = -32'($urandom_range(1, 1000));
            if (i % 5 == 0)                  rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else                             rb = 32'($urandom_range(1, 50));
            if (i % 3 == 2) rb = -rb;
            r = model(ro, ra, rb);
            issue(ro, ra, rb);
            wait_done($sformatf("rand%0d_op%0d", i, ro), r[63:32], r[31:0]);
        end
        @(negedge clk);

        // Reset mid-operation aborts it
        start = 1'b1; op = 3'd4; x = 32'hDEAD;
        @(negedge clk);
        op = 3'd5;
        @(negedge clk);
        start = 1'b0;
        issue(3'd3, 32'd1000, 32'd7);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort.hi", hi, 0);
        chk("abort.lo", lo, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
        end
        chk("abort.no_done", done_seen, 0);
        rst_n = 1'b1;
        issue(3'd3, 32'd9, 32'd3);
        wait_done("divu_after_reset", 32'd0, 32'd3);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the operand and HI/LO width; only W=32 is required to be supported.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset is asynchronous and active-low.
REQ-004 Port start, input, 1: request strobe, sampled on each rising clk edge.
REQ-005 Port op, input, 3: operation code. 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; codes 6 and 7 are no-ops.
REQ-006 Port x, input, W: first operand (multiplicand or dividend; the source for MTHI/MTLO).
REQ-007 Port y, input, W: second operand (multiplier or divisor).
REQ-008 Port hi, output, W: architectural HI register (product upper half or remainder).
REQ-009 Port lo, output, W: architectural LO register (product lower half or quotient).
REQ-010 Port busy, output, 1: high while an iterative operation is in progress.
REQ-011 Port done, output, 1: one-cycle pulse marking that hi/lo hold a new mul/div result.

Function
REQ-012 The block SHALL implement states IDLE, RUN and FIX.
REQ-013 In IDLE, the block SHALL accept start=1 with op 0-3 on edge E0: latch operands as magnitudes (absolute values for signed ops), record the result signs, clear the iteration counter and enter RUN.
REQ-014 RUN SHALL process one bit per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide; it SHALL stay in RUN for exactly W edges (E1..EW) and then enter FIX.
REQ-015 On edge EW+1 (FIX), the block SHALL apply sign correction, write hi and lo, pulse done for exactly one cycle and return to IDLE; latency from accepting edge to done is W+1 edges (33 for W=32).
REQ-016 busy SHALL be 1 from E0+ through the cycle before done, and 0 in the cycle where done=1.
REQ-017 hi and lo SHALL NOT change during RUN; they hold their old values until FIX.
REQ-018 A start while busy=1 SHALL be ignored, for every op, with no effect on state, hi, lo or the operation in progress.
REQ-019 A start in the cycle where done=1 SHALL be accepted, since busy=0 in that cycle.
REQ-020 MTHI or MTLO with start=1 in IDLE SHALL write x into hi or lo respectively on that edge, without asserting busy or done.
REQ-021 Ops 6 and 7 SHALL have no effect.
REQ-022 MULT/MULTU SHALL produce {hi,lo} equal to the full 2W-bit signed/unsigned product.
REQ-023 DIV SHALL produce a quotient truncated toward zero in lo, and a remainder in hi carrying the sign of x.
REQ-024 DIVU SHALL produce the unsigned quotient in lo and the unsigned remainder in hi.
REQ-025 On divide by zero, the block SHALL give hi=x; lo=all-ones for DIVU and for DIV with x>=0; lo=1 for DIV with x<0. No exception is raised.
REQ-026 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.

Reset
REQ-027 On rst_n=0, the block SHALL immediately and asynchronously force state=IDLE, hi=0, lo=0, busy=0, done=0, and clear the counter and operand registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no done pulse occurs for it.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With macro MULDIV_SIGNED_EN defined, MULT and DIV SHALL use signed semantics per REQ-022 to REQ-026.
REQ-031 Without MULDIV_SIGNED_EN, MULT and DIV SHALL behave identically to MULTU and DIVU (no sign logic is synthesised); latency is unchanged.

Verification
REQ-032 MULTU, x=0xFFFFFFFF, y=0xFFFFFFFF -> busy for 33 cycles, done at edge E33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT (MULDIV_SIGNED_EN defined), x=0xFFFFFFFE (-2), y=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; same stimulus without the macro -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 DIV x=0xFFFFFFF9 (-7), y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU x=7, y=0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 DIVU 100/7 started, then MTLO x=0x1234 and MULTU issued at E5 -> both ignored; at done lo=14, hi=2. Then MTLO x=0x1234 in IDLE -> lo=0x1234 next cycle, busy and done stay 0.
REQ-036 Back-to-back: second MULTU 3*5 asserted in the done cycle of the first op -> accepted, second done 33 cycles later with lo=15, hi=0.
REQ-037 rst_n pulsed low at RUN cycle 10 of DIVU -> hi=lo=0, busy=0 immediately, no done pulse; a fresh DIVU 9/3 afterwards -> lo=3, hi=0.
